// File: rtl/uart_pkg.sv
// Shared types and constants for the word-oriented 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} tx_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_DONE} word_state_t;

  localparam logic       UART_START_BIT = 1'b0;
  localparam logic       UART_STOP_BIT  = 1'b1;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word handshake between the Core and the UART word transmitter.
interface uart_word_tx_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer with a baud down-counter; accepts a new byte
// in the last stop-bit cycle so consecutive frames have no idle gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_byte_done,
  output logic       o_tx
);

  // state | meaning
  // IDLE  | line high, waiting for a byte
  // START | start bit (low)
  // DATA  | 8 data bits, LSB first
  // STOP  | stop bit (high); next byte may be taken on its last cycle
  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        r_state, w_state_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic             r_tx, w_tx_nxt;
  logic             w_bit_end;

  assign w_bit_end    = (r_cnt == '0);
  assign o_byte_done  = (r_state == STOP) && w_bit_end;
  assign o_byte_ready = (r_state == IDLE) || o_byte_done;
  assign o_tx         = r_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= UART_STOP_BIT;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_cnt_nxt   = r_cnt;
    if (r_state != IDLE && !w_bit_end) w_cnt_nxt = r_cnt - 1'b1;

    case (r_state)
      IDLE: begin
        if (i_byte_valid) begin
          w_state_nxt = START;
          w_shift_nxt = i_byte;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_cnt_nxt   = CNT_LOAD;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (i_byte_valid) begin
            w_state_nxt = START;
            w_shift_nxt = i_byte;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // tx is registered from the next state so it never glitches
    case (w_state_nxt)
      START:   w_tx_nxt = UART_START_BIT;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = UART_STOP_BIT;
    endcase
  end

endmodule

// File: rtl/uart_word_tx.sv
// Sends a latched 32-bit word as four 8N1 frames, MSB byte first.
// Define UART_TX_NEWLINE_EN to append CR and LF frames after each word.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 234,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_word_tx_if.slave  word_if,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  // state  | meaning
  // W_IDLE | ready for a word
  // W_SEND | frames of the latched word in flight
  // W_DONE | one-cycle completion pulse
`ifdef UART_TX_NEWLINE_EN
  localparam int IDX_W  = 3;
  localparam int FRAMES = BYTES_PER_WORD + 2;
`else
  localparam int IDX_W  = 2;
  localparam int FRAMES = BYTES_PER_WORD;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAMES - 1);

  word_state_t      r_state, w_state_nxt;
  logic [31:0]      r_word, w_word_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [IDX_W-1:0] w_sel;
  logic [7:0]       w_byte;
  logic             w_accept, w_last, w_byte_valid, w_byte_ready, w_byte_done;

  assign word_if.word_ready = (r_state == W_IDLE);
  assign busy               = (r_state == W_SEND);
  assign done               = (r_state == W_DONE);

  assign w_accept     = word_if.word_valid && word_if.word_ready && w_byte_ready;
  assign w_last       = (r_idx == LAST_IDX);
  // the next byte is offered during the last stop-bit cycle of the current one
  assign w_sel        = (r_state == W_IDLE) ? '0 : r_idx + 1'b1;
  assign w_byte_valid = w_accept || ((r_state == W_SEND) && w_byte_done && !w_last);

  always_comb begin
    w_byte = word_byte((r_state == W_IDLE) ? word_if.word_in : r_word, w_sel[1:0]);
`ifdef UART_TX_NEWLINE_EN
    if (w_sel == 3'd4)      w_byte = ASCII_CR;
    else if (w_sel == 3'd5) w_byte = ASCII_LF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= W_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    case (r_state)
      W_IDLE: begin
        if (w_accept) begin
          w_state_nxt = W_SEND;
          w_word_nxt  = word_if.word_in;
          w_idx_nxt   = '0;
        end
      end
      W_SEND: begin
        if (w_byte_done) begin
          if (w_last) w_state_nxt = W_DONE;
          else        w_idx_nxt   = r_idx + 1'b1;
        end
      end
      W_DONE: begin
        w_state_nxt = W_IDLE;
        w_idx_nxt   = '0;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_byte       (w_byte),
    .i_byte_valid (w_byte_valid),
    .o_byte_ready (w_byte_ready),
    .o_byte_done  (w_byte_done),
    .o_tx         (tx)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: a line decoder on the fast instance
// pops expected bytes; timing is checked on both fast and 234-clk instances.
module tb_uart_word_tx;

  localparam int C4   = 4;
  localparam int C234 = 234;
`ifdef UART_TX_NEWLINE_EN
  localparam int FRAMES = 6;
`else
  localparam int FRAMES = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_word_tx_if if4();
  uart_word_tx_if if234();
  logic tx4, busy4, done4, tx234, busy234, done234;

  uart_word_tx #(.CLKS_PER_BIT(C4), .BYTES_PER_WORD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .word_if(if4), .tx(tx4), .busy(busy4), .done(done4));
  uart_word_tx #(.CLKS_PER_BIT(C234), .BYTES_PER_WORD(4)) dut234 (
    .clk(clk), .rst_n(rst_n), .word_if(if234), .tx(tx234), .busy(busy234), .done(done234));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
`ifdef UART_TX_NEWLINE_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic wait_done4(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done4) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq("done4_timeout", 32'(done4), 32'd1);
  endtask

  task automatic wait_tx4_low(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx4 === 1'b0) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq("tx4_low_timeout", 32'(tx4), 32'd0);
  endtask

  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst_n && done4) done_cnt++;

  // 8N1 line decoder, mid-bit sampling on the CLKS_PER_BIT=4 instance
  int         rx_cnt = 0;
  bit         rx_active = 1'b0;
  logic [7:0] rx_sh = '0;
  always @(negedge clk) begin
    if (!rst_n) rx_active = 1'b0;
    else if (!rx_active) begin
      if (tx4 === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 2) check_eq("start_bit", 32'(tx4), 32'd0);
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh = {tx4, rx_sh[7:1]};
      if (rx_cnt == 38) begin
        check_eq("stop_bit", 32'(tx4), 32'd1);
        check_eq("rx_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
      end
      if (rx_cnt == 39) rx_active = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t, d1, s2, d2, dc, lr, hi;
    bit ready_hi;
    if4.word_in = '0;   if4.word_valid = 1'b0;
    if234.word_in = '0; if234.word_valid = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_tx", 32'(tx4), 32'd1);
    check_eq("rst_ready", 32'(if4.word_ready), 32'd1);
    check_eq("rst_busy", 32'(busy4), 32'd0);
    check_eq("rst_done", 32'(done4), 32'd0);
    check_eq("rst_tx234", 32'(tx234), 32'd1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // single "pass" word, valid for one cycle
    if4.word_in = 32'h7061_7373; if4.word_valid = 1'b1; push_word(32'h7061_7373);
    @(negedge clk);
    if4.word_valid = 1'b0; t0 = cyc; dc = done_cnt;
    check_eq("tx_latency", 32'(tx4), 32'd0);
    check_eq("busy_after_accept", 32'(busy4), 32'd1);
    check_eq("ready_after_accept", 32'(if4.word_ready), 32'd0);
    wait_done4(FRAMES * 40 + 20, t);
    check_eq("done_latency", 32'(t - t0), 32'(FRAMES * 40));
    check_eq("done_busy_low", 32'(busy4), 32'd0);
    @(negedge clk);
    check_eq("done_width", 32'(done4), 32'd0);
    check_eq("done_count", 32'(done_cnt - dc), 32'd1);
    check_eq("q_empty_1", 32'(exp_q.size()), 32'd0);
    check_eq("ready_after_done", 32'(if4.word_ready), 32'd1);

    // word_in churns and a stray valid pulse arrives while busy
    if4.word_in = 32'h1234_5678; if4.word_valid = 1'b1; push_word(32'h1234_5678);
    @(negedge clk);
    if4.word_valid = 1'b0; t0 = cyc; t = -1; ready_hi = 1'b0;
    for (int i = 0; i < FRAMES * 40 + 20; i++) begin
      @(negedge clk);
      if (done4) begin
        t = cyc;
        break;
      end
      if (if4.word_ready) ready_hi = 1'b1;
      if4.word_in    = $urandom;
      if4.word_valid = (i == 50);
    end
    if4.word_valid = 1'b0;
    check_eq("done_latency_2", 32'(t - t0), 32'(FRAMES * 40));
    check_eq("ready_while_busy", 32'(ready_hi), 32'd0);
    repeat (30) @(negedge clk);
    check_eq("stray_valid_ignored", 32'(busy4), 32'd0);
    check_eq("q_empty_2", 32'(exp_q.size()), 32'd0);

    // valid held high: two back-to-back "0A3C" words
    if4.word_in = 32'h3041_3343; if4.word_valid = 1'b1;
    push_word(32'h3041_3343); push_word(32'h3041_3343);
    wait_done4(FRAMES * 40 + 20, d1);
    wait_tx4_low(10, s2);
    check_eq("restart_gap", 32'(s2 - d1), 32'd2);
    wait_done4(FRAMES * 40 + 20, d2);
    if4.word_valid = 1'b0;
    check_eq("done_latency_3", 32'(d2 - s2), 32'(FRAMES * 40));
    repeat (60) @(negedge clk);
    check_eq("no_third_word", 32'(busy4), 32'd0);
    check_eq("q_empty_3", 32'(exp_q.size()), 32'd0);

    // async reset in the middle of byte 2's data bits
    if4.word_in = 32'h4243_4145; if4.word_valid = 1'b1; push_word(32'h4243_4145);
    @(negedge clk);
    if4.word_valid = 1'b0;
    repeat (88) @(negedge clk);
    check_eq("pre_reset_tx_low", 32'(tx4), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", 32'(tx4), 32'd1);
    check_eq("async_rst_busy", 32'(busy4), 32'd0);
    check_eq("async_rst_ready", 32'(if4.word_ready), 32'd1);
    dc = done_cnt;
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("no_done_after_reset", 32'(done_cnt - dc), 32'd0);

    // clean word after reset ("fail")
    if4.word_in = 32'h6661_696C; if4.word_valid = 1'b1; push_word(32'h6661_696C);
    @(negedge clk);
    if4.word_valid = 1'b0; t0 = cyc;
    check_eq("tx_latency_4", 32'(tx4), 32'd0);
    wait_done4(FRAMES * 40 + 20, t);
    check_eq("done_latency_4", 32'(t - t0), 32'(FRAMES * 40));
    @(negedge clk);
    check_eq("q_empty_4", 32'(exp_q.size()), 32'd0);

    // bit length on the 234-clock instance
    if234.word_in = 32'h4142_4344; if234.word_valid = 1'b1;
    @(negedge clk);
    if234.word_valid = 1'b0; t0 = cyc;
    check_eq("tx234_latency", 32'(tx234), 32'd0);
    lr = 1;
    for (int i = 0; i < 2 * C234; i++) begin
      @(negedge clk);
      if (tx234 === 1'b0) lr++;
      else break;
    end
    check_eq("start_bit_len", 32'(lr), 32'(C234));
    hi = 0; t = -1;
    for (int i = 0; i < FRAMES * 10 * C234 + 100; i++) begin
      @(negedge clk);
      if (tx234) hi++;
      else hi = 0;
      if (done234) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq("done234_timeout", 32'(done234), 32'd1);
    check_eq("last_stop_len", 32'(hi - 1), 32'(C234));
    check_eq("done234_latency", 32'(t - t0), 32'(FRAMES * 10 * C234));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Serializes the Core's 32-bit tx_word (four ASCII characters: hex PC digits, "pass" or "fail") onto a single UART TX pin, 8N1, most-significant byte first. Sits between Core.tx_word and the board's UART pin. Captures a whole word on a valid/ready handshake, so the 4 bytes of one word are never torn by later changes to tx_word.

Parameters:
CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); legal range 2..65535.
BYTES_PER_WORD, 4, number of bytes sent per word, taken from word_in MSB-first; fixed at 4 for this design.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
word_in  input  32  word to send; byte0 = [31:24], byte3 = [7:0]
word_valid  input  1  request to send word_in
word_ready  output  1  high when idle and able to accept a word
tx  output  1  UART serial line, idle high
busy  output  1  high from acceptance until the last stop bit completes
done  output  1  one-cycle pulse when the whole word, plus the optional newline, has been sent

Behaviour:
- Reset values:
  - Reset is asynchronous and active-low: rst_n=0 forces everything immediately, regardless of clk.
  - tx=1, word_ready=1, busy=0, done=0.
  - State IDLE; shift register, baud counter, bit index and byte index all 0.
- Handshake:
  - Acceptance occurs on the rising clk edge where word_valid && word_ready.
  - word_in is latched in full at that edge.
  - word_ready = (state==IDLE); it drops the cycle after acceptance.
  - word_valid while busy is ignored, not queued.
  - word_valid may stay high continuously; the next word is then accepted on the first IDLE cycle after done.
- State machine, one bit per CLKS_PER_BIT cycles:
  - IDLE -> START on acceptance.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB-first, tx=shift[0], each held CLKS_PER_BIT cycles -> STOP after bit 7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If bytes remain, -> START with the next byte loaded, no idle gap. Otherwise -> DONE.
  - DONE: one cycle, done=1, tx=1, busy=0 -> IDLE.
- Timing:
  - tx first goes low on the cycle after acceptance (latency 1).
  - A word occupies exactly 4*10*CLKS_PER_BIT cycles of tx activity. done fires on the cycle following the final stop bit.
- Baud counter:
  - Loads CLKS_PER_BIT-1 on entry to each bit and decrements to 0.
  - The transition happens at 0.
  - Width is $clog2(CLKS_PER_BIT).
- Byte index: 0..BYTES_PER_WORD-1, no wrap past the last byte. The byte is selected from the latched word, never from live word_in.
- Reset mid-frame: tx returns high asynchronously and the partial byte is abandoned. No done pulse is emitted.
- Changes to word_in after acceptance have no effect on the frame in flight.

Optional Feature:
UART_TX_NEWLINE_EN
- Defined: after the 4 word bytes, sends 8'h0D then 8'h0A as two further 8N1 frames, back-to-back. The word then takes 6*10*CLKS_PER_BIT cycles, and done fires after the LF stop bit.
- Undefined: exactly 4 frames per word, with no trailing bytes and no extra logic.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP, DONE}.
  - Constants UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
- Sub-module uart_byte_tx holds the START/DATA/STOP sequencing and baud counter for a single byte. It has a byte_valid/byte_ready handshake and a byte_done pulse.
- uart_word_tx keeps the word latch, byte index, optional CR/LF and the top-level handshake.

Test Plan:
- CLKS_PER_BIT=4, reset then word_in="pass" (0x70617373), valid 1 cycle:
  - tx low on the next cycle.
  - Decoded bytes are 0x70, 0x61, 0x73, 0x73 with stop bits high.
  - done pulses once, exactly 160 cycles after the cycle tx first went low.
- Changing word_in every cycle after acceptance: the transmitted bytes still equal the latched word; word_ready stays 0 until after done.
- word_valid held high with word_in="0A3C" (0x30413343): two identical back-to-back words; the second start bit begins 2 cycles after the first done.
- rst_n pulsed low mid-DATA of byte 2:
  - tx=1, busy=0, word_ready=1 immediately, with no clk edge needed.
  - No done pulse.
  - A new word then transmits cleanly.
- CLKS_PER_BIT=234: each bit is held exactly 234 cycles (measured on the first start bit and the last stop bit).
- With UART_TX_NEWLINE_EN defined: bytes 0x66, 0x61, 0x69, 0x6C, 0x0D, 0x0A are sent for "fail"; done pulses 240 cycles after first start (CLKS_PER_BIT=4).
